// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter sharing one 4-bit add_sub unit between two requesters.
// Each operation takes three cycles: grant (IDLE), issue (ISSUE), respond (RESP).
module add_sub_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic [3:0]       a_0,
  input  logic [3:0]       a_1,
  input  logic [3:0]       b_0,
  input  logic [3:0]       b_1,
  input  logic             op_0,
  input  logic             op_1,
  output logic             rsp_valid_0,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_0,
  input  logic             rsp_ready_1,
  output logic [4:0]       rsp_sum,
  output logic             rsp_cout,
  output logic [3:0]       au_a,
  output logic [3:0]       au_b,
  output logic             au_s,
  input  logic [4:0]       au_sum,
  input  logic             au_cout,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic             r_cur;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic             r_op;
  logic [4:0]       r_sum;
  logic             r_cout;
  logic [CNT_W-1:0] r_ops_done;

  logic             w_gnt_vld;
  logic             w_gnt;
  logic             w_req_hs;
  logic             w_rsp_hs;
  logic             w_req_ready_0;
  logic             w_req_ready_1;
  logic             w_rsp_valid_0;
  logic             w_rsp_valid_1;

  // Next-state, grant selection and handshake decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_vld     = 1'b0;
    w_gnt         = 1'b0;
    w_req_hs      = 1'b0;
    w_rsp_hs      = 1'b0;
    w_req_ready_0 = 1'b0;
    w_req_ready_1 = 1'b0;
    w_rsp_valid_0 = 1'b0;
    w_rsp_valid_1 = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid_0 && req_valid_1) begin
          w_gnt_vld = 1'b1;
          w_gnt     = ~r_last_grant;
        end else if (req_valid_0) begin
          w_gnt_vld = 1'b1;
          w_gnt     = 1'b0;
        end else if (req_valid_1) begin
          w_gnt_vld = 1'b1;
          w_gnt     = 1'b1;
        end else begin
          w_gnt_vld = 1'b0;
          w_gnt     = 1'b0;
        end
        // No acceptance is signalled while reset is pending, since it would be lost.
        w_req_hs      = w_gnt_vld && !rst;
        w_req_ready_0 = w_req_hs && !w_gnt;
        w_req_ready_1 = w_req_hs && w_gnt;
        if (w_req_hs) begin
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_rsp_valid_0 = !r_cur;
        w_rsp_valid_1 = r_cur;
        w_rsp_hs      = r_cur ? rsp_ready_1 : rsp_ready_0;
        if (w_rsp_hs) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Current owner and round-robin history; history moves only on a completed response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur        <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_req_hs) begin
        r_cur <= w_gnt;
      end
      if (w_rsp_hs) begin
        r_last_grant <= r_cur;
      end
    end
  end

  // Operand registers drive the unit and hold until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a  <= 4'd0;
      r_b  <= 4'd0;
      r_op <= 1'b0;
    end else if (w_req_hs) begin
      r_a  <= w_gnt ? a_1  : a_0;
      r_b  <= w_gnt ? b_1  : b_0;
      r_op <= w_gnt ? op_1 : op_0;
    end
  end

  // Result capture at the end of ISSUE; stable throughout RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= 5'd0;
      r_cout <= 1'b0;
    end else if (r_state == ST_ISSUE) begin
      r_sum  <= au_sum;
      r_cout <= au_cout;
    end
  end

  // Completed-operation counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ops_done <= '0;
    end else if (w_rsp_hs) begin
      r_ops_done <= r_ops_done + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign req_ready_0 = w_req_ready_0;
  assign req_ready_1 = w_req_ready_1;
  assign rsp_valid_0 = w_rsp_valid_0;
  assign rsp_valid_1 = w_rsp_valid_1;
  assign rsp_sum     = r_sum;
  assign rsp_cout    = r_cout;
  assign au_a        = r_a;
  assign au_b        = r_b;
  assign au_s        = r_op;
  assign busy        = (r_state != ST_IDLE);
  assign ops_done    = r_ops_done;

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Self-checking bench for add_sub_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of arbitration, latency and add_sub arithmetic.
module tb_add_sub_arbiter;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [3:0]    a_0, a_1, b_0, b_1;
  logic          op_0, op_1;
  logic          rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
  logic [4:0]    rsp_sum;
  logic          rsp_cout;
  logic [3:0]    au_a, au_b;
  logic          au_s;
  logic [4:0]    au_sum;
  logic          au_cout;
  logic          busy;
  logic [CW-1:0] ops_done;

  int   checks   = 0;
  int   failures = 0;
  int   m_ops;
  logic m_last;

  // Behavioural add_sub: S=0 adds, S=1 subtracts (two's complement, cout = no borrow).
  function automatic logic [5:0] add_sub_model(input logic [3:0] a, input logic [3:0] b, input logic s);
    int r;
    logic c;
    if (!s) begin
      r = int'(a) + int'(b);
      c = (r > 15);
    end else begin
      r = int'(a) - int'(b);
      c = (a >= b);
    end
    return {c, r[4:0]};
  endfunction

  assign {au_cout, au_sum} = add_sub_model(au_a, au_b, au_s);

  add_sub_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .a_0(a_0), .a_1(a_1), .b_0(b_0), .b_1(b_1), .op_0(op_0), .op_1(op_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .au_a(au_a), .au_b(au_b), .au_s(au_s), .au_sum(au_sum), .au_cout(au_cout),
    .busy(busy), .ops_done(ops_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] outs;
    rst = 1'b1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0; rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    a_0 = 4'd0; a_1 = 4'd0; b_0 = 4'd0; b_1 = 4'd0; op_0 = 1'b0; op_1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    outs = {busy, rsp_valid_0, rsp_valid_1, req_ready_0, req_ready_1, rsp_sum, rsp_cout, au_a, au_b, au_s};
    checks++;
    if (outs !== 20'd0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    checks++;
    if (ops_done !== 2'd0) begin failures++; $display("FAIL reset_ops_done: got %0d expected 0", ops_done); end
    m_ops = 0;
    m_last = 1'b1;
  endtask

  task automatic test_single();
    a_0 = 4'b0101; b_0 = 4'b0011; op_0 = 1'b0; req_valid_0 = 1'b1; rsp_ready_0 = 1'b1;
    #1;
    checks++;
    if ({req_ready_0, req_ready_1} !== 2'b10) begin failures++; $display("FAIL single_req_ready: got %b expected 10", {req_ready_0, req_ready_1}); end
    tick();
    req_valid_0 = 1'b0;
    #1;
    checks++;
    if ({au_a, au_b, au_s, busy, rsp_valid_0} !== {4'b0101, 4'b0011, 1'b0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL single_issue: got a=%b b=%b s=%b busy=%b v0=%b expected 0101 0011 0 1 0", au_a, au_b, au_s, busy, rsp_valid_0);
    end
    tick();
    checks++;
    if ({rsp_valid_0, rsp_valid_1, rsp_sum, rsp_cout} !== {1'b1, 1'b0, 5'b01000, 1'b0}) begin
      failures++; $display("FAIL single_resp: got v0=%b v1=%b sum=%b cout=%b expected 1 0 01000 0", rsp_valid_0, rsp_valid_1, rsp_sum, rsp_cout);
    end
    tick();
    m_ops = 1; m_last = 1'b0;
    checks++;
    if ({busy, ops_done} !== {1'b0, 2'd1}) begin failures++; $display("FAIL single_done: got busy=%b ops=%0d expected 0 1", busy, ops_done); end
  endtask

  task automatic test_backpressure();
    logic [5:0] e0, e1;
    a_0 = 4'($urandom); b_0 = 4'($urandom); op_0 = 1'($urandom);
    e0 = add_sub_model(a_0, b_0, op_0);
    req_valid_0 = 1'b1; rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b1;
    #1;
    checks++;
    if (req_ready_0 !== 1'b1) begin failures++; $display("FAIL bp_grant0: got %b expected 1", req_ready_0); end
    tick();
    req_valid_0 = 1'b0;
    a_1 = 4'($urandom); b_1 = 4'($urandom); op_1 = 1'($urandom); req_valid_1 = 1'b1;
    e1 = add_sub_model(a_1, b_1, op_1);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid_0, rsp_valid_1, rsp_cout, rsp_sum, req_ready_0, req_ready_1, busy} !== {1'b1, 1'b0, e0, 1'b0, 1'b0, 1'b1}) begin
        failures++; $display("FAIL bp_stall[%0d]: got v=%b%b res=%b rr=%b%b busy=%b expected v=10 res=%b rr=00 busy=1",
                             i, rsp_valid_0, rsp_valid_1, {rsp_cout, rsp_sum}, req_ready_0, req_ready_1, busy, e0);
      end
      tick();
    end
    rsp_ready_0 = 1'b1;
    #1;
    tick();
    checks++;
    if ({req_ready_1, req_ready_0, ops_done} !== {1'b1, 1'b0, 2'd2}) begin
      failures++; $display("FAIL bp_next_grant: got rr1=%b rr0=%b ops=%0d expected 1 0 2", req_ready_1, req_ready_0, ops_done);
    end
    tick();
    req_valid_1 = 1'b0;
    tick();
    checks++;
    if ({rsp_valid_1, rsp_valid_0, rsp_cout, rsp_sum} !== {1'b1, 1'b0, e1}) begin
      failures++; $display("FAIL bp_resp1: got v1=%b v0=%b res=%b expected 1 0 %b", rsp_valid_1, rsp_valid_0, {rsp_cout, rsp_sum}, e1);
    end
    tick();
    m_ops = 3; m_last = 1'b1;
    checks++;
    if (ops_done !== 2'd3) begin failures++; $display("FAIL bp_ops: got %0d expected 3", ops_done); end
  endtask

  task automatic test_reset_midop();
    logic [19:0] outs;
    for (int k = 0; k < 2; k++) begin
      a_0 = 4'($urandom_range(15, 1)); b_0 = 4'($urandom_range(15, 1)); op_0 = 1'($urandom);
      req_valid_0 = 1'b1; rsp_ready_0 = 1'b0;
      tick();
      req_valid_0 = 1'b0;
      if (k == 1) begin
        tick();
        checks++;
        if (rsp_valid_0 !== 1'b1) begin failures++; $display("FAIL midrst_in_resp: got %b expected 1", rsp_valid_0); end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
        #1;
        outs = {busy, rsp_valid_0, rsp_valid_1, req_ready_0, req_ready_1, rsp_sum, rsp_cout, au_a, au_b, au_s};
        checks++;
        if (outs !== 20'd0 || ops_done !== 2'd0) begin
          failures++; $display("FAIL midrst[%0d][%0d]: got outs=%h ops=%0d expected 0 0", k, c, outs, ops_done);
        end
        tick();
      end
    end
    rsp_ready_0 = 1'b1;
    m_ops = 0; m_last = 1'b1;
  endtask

  task automatic test_only_req1();
    logic [5:0] e;
    a_1 = 4'($urandom); b_1 = 4'($urandom); op_1 = 1'($urandom);
    e = add_sub_model(a_1, b_1, op_1);
    req_valid_0 = 1'b0; req_valid_1 = 1'b1; rsp_ready_1 = 1'b1; rsp_ready_0 = 1'b1;
    #1;
    checks++;
    if ({req_ready_1, req_ready_0} !== 2'b10) begin failures++; $display("FAIL only1_grant: got %b%b expected 10", req_ready_1, req_ready_0); end
    tick();
    req_valid_1 = 1'b0;
    #1;
    checks++;
    if ({au_a, au_b, au_s, rsp_valid_0} !== {a_1, b_1, op_1, 1'b0}) begin
      failures++; $display("FAIL only1_issue: got %b%b%b v0=%b expected %b%b%b 0", au_a, au_b, au_s, rsp_valid_0, a_1, b_1, op_1);
    end
    tick();
    checks++;
    if ({rsp_valid_1, rsp_valid_0, rsp_cout, rsp_sum} !== {1'b1, 1'b0, e}) begin
      failures++; $display("FAIL only1_resp: got v1=%b v0=%b res=%b expected 1 0 %b", rsp_valid_1, rsp_valid_0, {rsp_cout, rsp_sum}, e);
    end
    tick();
    m_ops = 1; m_last = 1'b1;
    checks++;
    if ({ops_done, rsp_valid_0} !== {2'd1, 1'b0}) begin failures++; $display("FAIL only1_done: got ops=%0d v0=%b expected 1 0", ops_done, rsp_valid_0); end
  endtask

  task automatic test_alternate();
    logic       g;
    logic [3:0] ea, eb;
    logic       es;
    logic [5:0] e;
    a_1 = 4'b1001; b_1 = 4'b0110; op_1 = 1'b1;
    a_0 = 4'($urandom); b_0 = 4'($urandom); op_0 = 1'b0;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1; rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      g = ~m_last;
      #1;
      checks++;
      if ({req_ready_1, req_ready_0} !== {g, ~g}) begin
        failures++; $display("FAIL alt_grant[%0d]: got rr1=%b rr0=%b expected %b %b", i, req_ready_1, req_ready_0, g, ~g);
      end
      ea = g ? a_1 : a_0; eb = g ? b_1 : b_0; es = g ? op_1 : op_0;
      e = add_sub_model(ea, eb, es);
      tick();
      if (!g) begin a_0 = 4'($urandom); b_0 = 4'($urandom); op_0 = 1'($urandom); end
      #1;
      checks++;
      if ({au_a, au_b, au_s} !== {ea, eb, es}) begin failures++; $display("FAIL alt_issue[%0d]: got %b expected %b", i, {au_a, au_b, au_s}, {ea, eb, es}); end
      tick();
      checks++;
      if ({rsp_valid_1, rsp_valid_0, rsp_cout, rsp_sum} !== {g, ~g, e}) begin
        failures++; $display("FAIL alt_resp[%0d]: got v=%b%b res=%b expected %b%b %b", i, rsp_valid_1, rsp_valid_0, {rsp_cout, rsp_sum}, g, ~g, e);
      end
      tick();
      m_ops++; m_last = g;
      checks++;
      if (ops_done !== CW'(m_ops)) begin failures++; $display("FAIL alt_ops[%0d]: got %0d expected %0d", i, ops_done, m_ops % 4); end
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
  endtask

  task automatic test_random();
    logic       mb = 1'b0;
    logic       cur = 1'b0;
    logic       gv, g, done;
    int         age = 0;
    logic [3:0] ea = 4'd0, eb = 4'd0;
    logic       es = 1'b0;
    logic [5:0] e = 6'd0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!mb) begin
        req_valid_0 = ($urandom_range(99) < 45); req_valid_1 = ($urandom_range(99) < 45);
        a_0 = 4'($urandom); b_0 = 4'($urandom); op_0 = 1'($urandom);
        a_1 = 4'($urandom); b_1 = 4'($urandom); op_1 = 1'($urandom);
      end
      rsp_ready_0 = ($urandom_range(99) < 60); rsp_ready_1 = ($urandom_range(99) < 60);
      #1;
      done = 1'b0;
      if (!mb) begin
        gv = req_valid_0 | req_valid_1;
        g  = (req_valid_0 && req_valid_1) ? ~m_last : req_valid_1;
        checks++;
        if ({req_ready_1, req_ready_0, busy, rsp_valid_1, rsp_valid_0} !== {gv && g, gv && !g, 3'b000}) begin
          failures++; $display("FAIL rnd_idle[%0d]: got rr=%b%b busy=%b v=%b%b expected rr=%b%b busy=0 v=00",
                               cyc, req_ready_1, req_ready_0, busy, rsp_valid_1, rsp_valid_0, gv && g, gv && !g);
        end
        if (gv) begin
          mb = 1'b1; age = 0; cur = g;
          ea = g ? a_1 : a_0; eb = g ? b_1 : b_0; es = g ? op_1 : op_0;
          e = add_sub_model(ea, eb, es);
        end
      end else begin
        checks++;
        if ({req_ready_1, req_ready_0, busy} !== 3'b001) begin
          failures++; $display("FAIL rnd_busy[%0d]: got rr=%b%b busy=%b expected rr=00 busy=1", cyc, req_ready_1, req_ready_0, busy);
        end
        checks++;
        if (age == 1) begin
          if ({au_a, au_b, au_s, rsp_valid_1, rsp_valid_0} !== {ea, eb, es, 2'b00}) begin
            failures++; $display("FAIL rnd_issue[%0d]: got %b v=%b%b expected %b v=00", cyc, {au_a, au_b, au_s}, rsp_valid_1, rsp_valid_0, {ea, eb, es});
          end
        end else begin
          if ({rsp_valid_1, rsp_valid_0, rsp_cout, rsp_sum} !== {cur, ~cur, e}) begin
            failures++; $display("FAIL rnd_resp[%0d]: got v=%b%b res=%b expected v=%b%b res=%b", cyc, rsp_valid_1, rsp_valid_0, {rsp_cout, rsp_sum}, cur, ~cur, e);
          end
          done = cur ? rsp_ready_1 : rsp_ready_0;
        end
      end
      checks++;
      if (ops_done !== CW'(m_ops)) begin failures++; $display("FAIL rnd_ops[%0d]: got %0d expected %0d", cyc, ops_done, m_ops % 4); end
      tick();
      if (done) begin
        mb = 1'b0; m_last = cur; m_ops++;
      end else if (mb) begin
        age++;
      end
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_reset_midop();
    test_only_req1();
    test_alternate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
